// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA framebuffer arbiter and its write FIFO.
package vga_pkg;

    localparam int unsigned PIX_W        = 24;
    localparam int unsigned H_AW         = 10;
    localparam int unsigned V_AW         = 9;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_V_ACTIVE = 480;

    typedef struct packed {
        logic [H_AW-1:0]  h;
        logic [V_AW-1:0]  v;
        logic [PIX_W-1:0] data;
    } wr_req_t;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DISP  = 1'b1
    } disp_state_e;

    // True when a queued write targets a visible pixel.
    function automatic logic req_in_range(input wr_req_t r, input int unsigned h_lim,
                                          input int unsigned v_lim);
        return (32'(r.h) < h_lim) && (32'(r.v) < v_lim);
    endfunction

endpackage

// File: rtl/vga_fb_wfifo.sv
// Synchronous FIFO of pending framebuffer writes; push is ignored when full, pop when empty.
module vga_fb_wfifo
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  wr_req_t                  i_din,
    input  logic                     i_pop,
    output wr_req_t                  o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    wr_req_t          mem_q [DEPTH];
    wr_req_t          mem_d [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign o_full  = (level_q == (PTR_W+1)'(DEPTH));
    assign o_empty = (level_q == '0);
    assign o_level = level_q;
    assign o_head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        push_ok  = i_push && !o_full;
        pop_ok   = i_pop && !o_empty;
        if (push_ok) begin
            mem_d[wr_ptr_q] = i_din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (PTR_W+1)'(1);
            2'b01:   level_d = level_q - (PTR_W+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/vga_fb_arb.sv
// Framebuffer port arbiter: display reads win during active video, queued writes retire in blanking.
// Optional statistics counters are built when VGA_FB_ARB_STAT_EN is defined.
module vga_fb_arb
    import vga_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid,
    input  logic [9:0]                   i_h_addr,
    input  logic [9:0]                   i_v_addr,
    output logic [PIX_W-1:0]             o_vga_data,
    input  logic                         i_wr_valid,
    output logic                         o_wr_ready,
    input  logic [H_AW-1:0]              i_wr_h,
    input  logic [V_AW-1:0]              i_wr_v,
    input  logic [PIX_W-1:0]             i_wr_data,
    output logic                         o_mem_en,
    output logic                         o_mem_we,
    output logic [H_AW-1:0]              o_mem_h,
    output logic [V_AW-1:0]              o_mem_v,
    output logic [PIX_W-1:0]             o_mem_wdata,
    input  logic [PIX_W-1:0]             i_mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]  o_fifo_level
`ifdef VGA_FB_ARB_STAT_EN
    ,
    output logic [15:0]                  o_stat_wr,
    output logic [15:0]                  o_stat_drop
`endif
);

    disp_state_e state_q, state_d;
    wr_req_t     wr_in;
    wr_req_t     head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        head_ok;
    logic        unused_v_msb;

    assign unused_v_msb = i_v_addr[9];

    assign wr_in      = '{h: i_wr_h, v: i_wr_v, data: i_wr_data};
    assign o_wr_ready = !i_rst && !fifo_full;
    assign push       = i_wr_valid && o_wr_ready;
    assign pop        = !i_rst && !i_valid && !fifo_empty;
    assign head_ok    = req_in_range(head, H_ACTIVE, V_ACTIVE);

    vga_fb_wfifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wfifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_din   (wr_in),
        .i_pop   (pop),
        .o_head  (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_level (o_fifo_level)
    );

    // Remembers whether last cycle issued a display read, so the returning data is shown.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_BLANK;
        if (i_valid) begin
            state_d = ST_DISP;
        end
    end

    always_comb begin
        o_vga_data = '0;
        if (state_q == ST_DISP) begin
            o_vga_data = i_mem_rdata;
        end
    end

    // Out-of-range heads are popped with the port left idle.
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_h     = i_h_addr;
        o_mem_v     = i_v_addr[V_AW-1:0];
        o_mem_wdata = head.data;
        if (!i_rst) begin
            if (i_valid) begin
                o_mem_en = 1'b1;
            end else if (!fifo_empty) begin
                o_mem_h  = head.h;
                o_mem_v  = head.v;
                o_mem_en = head_ok;
                o_mem_we = head_ok;
            end
        end
    end

`ifdef VGA_FB_ARB_STAT_EN
    logic [15:0] stat_wr_q, stat_wr_d;
    logic [15:0] stat_drop_q, stat_drop_d;

    always_comb begin
        stat_wr_d   = stat_wr_q;
        stat_drop_d = stat_drop_q;
        if (pop) begin
            if (head_ok) begin
                stat_wr_d = stat_wr_q + 16'd1;
            end else begin
                stat_drop_d = stat_drop_q + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stat_wr_q   <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_wr_q   <= stat_wr_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign o_stat_wr   = stat_wr_q;
    assign o_stat_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_vga_fb_arb.sv
// Randomized bench for vga_fb_arb against a queue-based model of the arbiter and framebuffer.
module tb_vga_fb_arb;

    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic [9:0]  h;
        logic [8:0]  v;
        logic [23:0] d;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic [23:0] vga_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_h;
    logic [8:0]  wr_v;
    logic [23:0] wr_data;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_h;
    logic [8:0]  mem_v;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata = '0;
    logic [3:0]  fifo_level;
`ifdef VGA_FB_ARB_STAT_EN
    logic [15:0] stat_wr;
    logic [15:0] stat_drop;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    req_t        q[$];
    logic [23:0] fb     [int];
    logic [23:0] golden [int];
    logic [23:0] exp_vga = '0;
    logic [15:0] m_stat_wr = '0;
    logic [15:0] m_stat_drop = '0;

    always #5 clk = ~clk;

    vga_fb_arb #(.FIFO_DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (valid),
        .i_h_addr     (h_addr),
        .i_v_addr     (v_addr),
        .o_vga_data   (vga_data),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .i_wr_h       (wr_h),
        .i_wr_v       (wr_v),
        .i_wr_data    (wr_data),
        .o_mem_en     (mem_en),
        .o_mem_we     (mem_we),
        .o_mem_h      (mem_h),
        .o_mem_v      (mem_v),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .o_fifo_level (fifo_level)
`ifdef VGA_FB_ARB_STAT_EN
        ,
        .o_stat_wr    (stat_wr),
        .o_stat_drop  (stat_drop)
`endif
    );

    function automatic int key_of(input logic [9:0] h, input logic [8:0] v);
        return int'({v, h});
    endfunction

    // Pixels never written hold an address-derived pattern.
    function automatic logic [23:0] fb_rd(input int k);
        if (fb.exists(k)) return fb[k];
        return 24'h5A0000 ^ 24'(k);
    endfunction

    function automatic logic [23:0] gold_rd(input int k);
        if (golden.exists(k)) return golden[k];
        return 24'h5A0000 ^ 24'(k);
    endfunction

    // Framebuffer: single port, synchronous read.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= fb_rd(key_of(mem_h, mem_v));
        if (mem_en && mem_we)  fb[key_of(mem_h, mem_v)] = mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance the model at the edge.
    task automatic step(input logic r, input logic vl, input logic [9:0] h, input logic [9:0] v,
                        input logic wv, input logic [9:0] wh, input logic [8:0] wvr,
                        input logic [23:0] wd);
        logic e_en, e_we, in_rng, do_push;
        req_t hd;
        rst = r; valid = vl; h_addr = h; v_addr = v;
        wr_valid = wv; wr_h = wh; wr_v = wvr; wr_data = wd;
        if (r) begin
            q.delete();
            exp_vga = '0;
            m_stat_wr = '0;
            m_stat_drop = '0;
        end
        @(negedge clk);
        e_en = 1'b0; e_we = 1'b0; in_rng = 1'b0;
        if (q.size() > 0) begin
            hd = q[0];
            in_rng = (hd.h < 10'd640) && (hd.v < 9'd480);
        end
        if (!r) begin
            if (vl) e_en = 1'b1;
            else if (q.size() > 0) begin e_en = in_rng; e_we = in_rng; end
        end
        chk("ready", 32'(wr_ready), 32'(!r && q.size() < DEPTH));
        chk("level", 32'(fifo_level), 32'(q.size()));
        chk("mem_en", 32'(mem_en), 32'(e_en));
        if (e_en) begin
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_h", 32'(mem_h), e_we ? 32'(hd.h) : 32'(h));
            chk("mem_v", 32'(mem_v), e_we ? 32'(hd.v) : 32'(v[8:0]));
            if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(hd.d));
        end
        chk("vga_data", 32'(vga_data), 32'(exp_vga));
`ifdef VGA_FB_ARB_STAT_EN
        chk("stat_wr", 32'(stat_wr), 32'(m_stat_wr));
        chk("stat_drop", 32'(stat_drop), 32'(m_stat_drop));
`endif
        @(posedge clk);
        if (!r) begin
            do_push = wv && (q.size() < DEPTH);
            exp_vga = vl ? gold_rd(key_of(h, v[8:0])) : 24'h0;
            if (!vl && q.size() > 0) begin
                hd = q.pop_front();
                if (in_rng) begin
                    golden[key_of(hd.h, hd.v)] = hd.d;
                    m_stat_wr++;
                end else begin
                    m_stat_drop++;
                end
            end
            if (do_push) q.push_back('{h: wh, v: wvr, d: wd});
        end
        #1;
    endtask

    task automatic idle(input logic vl, input int n);
        for (int i = 0; i < n; i++) step(1'b0, vl, 10'd3, 10'd4, 1'b0, '0, '0, '0);
    endtask

    initial begin
        logic       vis;
        int         vcnt;
        logic [9:0] rh, rv, wh;
        logic [8:0] wvr;
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        step(1'b1, 1'b1, '0, '0, 1'b1, 10'd1, 9'd1, 24'h1);
        // Write offered in active video, retired at the first blank cycle.
        step(1'b0, 1'b1, 10'd1, 10'd1, 1'b1, 10'd5, 9'd7, 24'hFF0000);
        step(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, '0, '0, '0);
        idle(1'b0, 2);
        // Nine back-to-back writes into an eight-deep FIFO during video.
        for (int i = 0; i < 9; i++)
            step(1'b0, 1'b1, 10'(i), 10'd2, 1'b1, 10'(20 + i), 9'd3, 24'(24'h100000 + i));
        idle(1'b0, 10);
        // Read-back path after writing a known pixel.
        step(1'b0, 1'b0, '0, '0, 1'b1, 10'd100, 9'd200, 24'h00A0B0);
        idle(1'b0, 1);
        step(1'b0, 1'b1, 10'd100, 10'd200, 1'b0, '0, '0, '0);
        step(1'b0, 1'b0, 10'd100, 10'd200, 1'b0, '0, '0, '0);
        idle(1'b0, 1);
        // Out-of-range column dropped, last visible row written.
        step(1'b0, 1'b1, 10'd0, 10'd0, 1'b1, 10'd640, 9'd10, 24'h123456);
        step(1'b0, 1'b1, 10'd0, 10'd0, 1'b1, 10'd10, 9'd479, 24'h654321);
        idle(1'b0, 3);
        step(1'b0, 1'b1, 10'd10, 10'd479, 1'b0, '0, '0, '0);
        // Push and pop in the same blank cycle at level four.
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, '0, '0, 1'b1, 10'(40 + i), 9'd9, 24'(24'hAB0000 + i));
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, '0, '0, 1'b1, 10'(50 + i), 9'd9, 24'(24'hCD0000 + i));
        idle(1'b0, 8);
        // Reset mid-frame with three entries queued.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 10'(i), 10'd5, 1'b1, 10'(60 + i), 9'd5, 24'(24'hEE0000 + i));
        step(1'b1, 1'b1, 10'd7, 10'd5, 1'b0, '0, '0, '0);
        idle(1'b0, 4);
        vis = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (vcnt == 0) begin
                vis = !vis;
                vcnt = int'($urandom_range(1, 20));
            end
            vcnt--;
            rh  = 10'($urandom_range(0, 15));
            rv  = 10'($urandom_range(0, 7));
            wh  = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(640, 1023))
                                              : 10'($urandom_range(0, 15));
            wvr = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(480, 511))
                                              : 9'($urandom_range(0, 7));
            step(($urandom_range(0, 599) == 0), vis, rh, rv, ($urandom_range(0, 2) != 0),
                 wh, wvr, 24'($urandom));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
